hdmi_src_arb: RTL and testbench

HDMI_SRC_ARB -- requirements
Module: hdmi_src_arb

---
 rtl/hdmi_src_arb.sv | 159 +++++++++++++++
 tb/tb_hdmi_src_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_src_arb.sv
// hdmi_src_arb: arbitrates N_SRC first-word-fall-through source FIFOs onto
// a single sink through a one-word output register.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sel, auto_rr  manual source index / round-robin enable
//   src_empty     per-source empty flags (bit i = source i)
//   src_data      per-source FWFT data, source i at [i*DW +: DW]
//   src_rd_en     per-source pop strobe (one-hot while popping)
//   out_empty     sink empty (no word buffered)
//   out_data      sink data, valid while out_empty = 0
//   out_rd_en     sink pop strobe
//   cur_src       index of the granted source
//   burst_done    one-cycle pulse after the last pop of a full burst
module hdmi_src_arb #(
    parameter int N_SRC     = 2,
    parameter int DW        = 8,
    parameter int BURST_LEN = 1024,
    parameter int SW        = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW-1:0]       sel,
    input  logic                auto_rr,
    input  logic [N_SRC-1:0]    src_empty,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic [N_SRC-1:0]    src_rd_en,
    output logic                out_empty,
    output logic [DW-1:0]       out_data,
    input  logic                out_rd_en,
    output logic [SW-1:0]       cur_src,
    output logic                burst_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    localparam int NSEL = 2 ** SW;

    logic [0:0]    state;
    logic [SW-1:0] last_grant;
    logic [15:0]   cnt;
    logic          buf_valid;
    logic [DW-1:0] buf_data;

    // Sources padded out to the full select range; indices beyond
    // N_SRC look permanently empty so they can never be granted.
    logic [NSEL-1:0] empty_ext;
    logic [DW-1:0]   data_arr [NSEL];

    always_comb begin
        empty_ext = '1;
        for (int i = 0; i < NSEL; i++) begin
            data_arr[i] = '0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            empty_ext[i] = src_empty[i];
            data_arr[i]  = src_data[i*DW +: DW];
        end
    end

    logic sel_ok;
    assign sel_ok = (int'(sel) < N_SRC);

    // Round-robin search upward from last_grant+1, wrapping at N_SRC.
    logic          rr_found;
    logic [SW-1:0] rr_idx;

    always_comb begin : rr_search
        int j;
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            j = (int'(last_grant) + k) % N_SRC;
            if (!rr_found && !empty_ext[SW'(j)]) begin
                rr_found = 1'b1;
                rr_idx   = SW'(j);
            end
        end
    end

    logic pop;
    logic burst_last;

    assign pop = (state == S_XFER)
               && !empty_ext[cur_src]
               && (!buf_valid || out_rd_en);

    assign burst_last = (cnt == 16'(BURST_LEN - 1));

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_rd_en[i] = pop && (int'(cur_src) == i);
        end
    end

    assign out_empty = !buf_valid;
    assign out_data  = buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_src    <= '0;
            last_grant <= SW'(N_SRC - 1);
            cnt        <= '0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;

            // Output register: a pop refills it even while the sink
            // drains it, so back-to-back words flow at one per cycle.
            if (pop) begin
                buf_valid <= 1'b1;
                buf_data  <= data_arr[cur_src];
            end else if (out_rd_en) begin
                buf_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!auto_rr) begin
                        if (sel_ok && !empty_ext[sel]) begin
                            state      <= S_XFER;
                            cur_src    <= sel;
                            last_grant <= sel;
                            cnt        <= '0;
                        end
                    end else if (rr_found) begin
                        state      <= S_XFER;
                        cur_src    <= rr_idx;
                        last_grant <= rr_idx;
                        cnt        <= '0;
                    end
                end
                S_XFER: begin
                    if (pop) begin
                        if (burst_last) begin
                            state      <= S_IDLE;
                            cnt        <= '0;
                            burst_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (empty_ext[cur_src]
                                 && (auto_rr || sel != cur_src)) begin
                        // Manual mode pointing at the same source keeps
                        // the grant so a refilled FIFO resumes its burst.
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_src_arb.sv
// tb_hdmi_src_arb: directed self-checking bench for hdmi_src_arb.
// Two queue-backed FWFT sources, BURST_LEN = 4.
module tb_hdmi_src_arb;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int SW = 3;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [SW-1:0]     sel       = '0;
    logic              auto_rr   = 1'b0;
    logic [N-1:0]      src_empty = '1;
    logic [N*DW-1:0]   src_data  = '0;
    logic [N-1:0]      src_rd_en;
    logic              out_empty;
    logic [DW-1:0]     out_data;
    logic              out_rd_en = 1'b0;
    logic [SW-1:0]     cur_src;
    logic              burst_done;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] junk;

    hdmi_src_arb #(
        .N_SRC     (N),
        .DW        (DW),
        .BURST_LEN (BL),
        .SW        (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .auto_rr    (auto_rr),
        .src_empty  (src_empty),
        .src_data   (src_data),
        .src_rd_en  (src_rd_en),
        .out_empty  (out_empty),
        .out_data   (out_data),
        .out_rd_en  (out_rd_en),
        .cur_src    (cur_src),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    // FWFT source model: pop on strobe, present new head after the edge.
    always @(posedge clk) begin
        if (src_rd_en[0] && q0.size() > 0) junk = q0.pop_front();
        if (src_rd_en[1] && q1.size() > 0) junk = q1.pop_front();
        src_empty <= {q1.size() == 0, q0.size() == 0};
        src_data  <= {(q1.size() > 0) ? q1[0] : 8'h00,
                      (q0.size() > 0) ? q0[0] : 8'h00};
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] log_q [$];
    logic [7:0] exp_ord [12];
    int         nbd;

    initial begin
        exp_ord = '{8'h40, 8'h41, 8'h42, 8'h43,
                    8'h50, 8'h51, 8'h52, 8'h53,
                    8'h44, 8'h45, 8'h54, 8'h55};

        // Reset values
        #1;
        chk("rst out_empty", 32'(out_empty), 32'd1);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst rd_en", 32'(src_rd_en), 32'h0);
        chk("rst cur_src", 32'(cur_src), 32'h0);
        chk("rst burst_done", 32'(burst_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual sel=1, sink always reading, 4-word burst
        sel = 3'd1;
        out_rd_en = 1'b1;
        for (int k = 0; k < 4; k++) q1.push_back(8'hA0 + 8'(k));
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("man rd_en", 32'(src_rd_en), 32'h2);
            if (k > 0) begin
                chk("man data", 32'(out_data), 32'hA0 + k - 1);
            end
        end
        tick();
        chk("man last data", 32'(out_data), 32'hA3);
        chk("man rd_en idle", 32'(src_rd_en), 32'h0);
        chk("man burst_done", 32'(burst_done), 32'h1);
        tick();
        chk("man drained", 32'(out_empty), 32'h1);
        chk("man bd low", 32'(burst_done), 32'h0);

        // Sink stall with one word buffered
        sel = 3'd0;
        out_rd_en = 1'b0;
        q0.push_back(8'h10);
        q0.push_back(8'h11);
        q0.push_back(8'h12);
        tick();
        tick();
        chk("stall first pop", 32'(src_rd_en), 32'h1);
        tick();
        chk("stall rd_en 1", 32'(src_rd_en), 32'h0);
        chk("stall data 1", 32'(out_data), 32'h10);
        tick();
        chk("stall rd_en 2", 32'(src_rd_en), 32'h0);
        chk("stall data 2", 32'(out_data), 32'h10);
        out_rd_en = 1'b1;
        #1;
        chk("stall release", 32'(src_rd_en), 32'h1);
        tick();
        chk("stall data 3", 32'(out_data), 32'h11);
        tick();
        chk("stall data 4", 32'(out_data), 32'h12);
        chk("stall src empty", 32'(src_rd_en), 32'h0);
        sel = 3'd1;
        tick();
        chk("stall out empty", 32'(out_empty), 32'h1);
        chk("stall cur hold", 32'(cur_src), 32'h0);

        // Out-of-range sel stays idle
        sel = 3'd5;
        q0.push_back(8'h77);
        q1.push_back(8'h77);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sel5 rd_en", 32'(src_rd_en), 32'h0);
            chk("sel5 out_empty", 32'(out_empty), 32'h1);
        end
        chk("sel5 cur hold", 32'(cur_src), 32'h0);
        q0.delete();
        q1.delete();
        tick();

        // sel change mid-burst is deferred to the burst end
        for (int k = 0; k < 6; k++) q0.push_back(8'hB0 + 8'(k));
        q1.push_back(8'hC0);
        q1.push_back(8'hC1);
        tick();
        sel = 3'd0;
        tick();
        chk("defer grant", 32'(cur_src), 32'h0);
        chk("defer rd_en", 32'(src_rd_en), 32'h1);
        sel = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("defer hold", 32'(cur_src), 32'h0);
        end
        tick();
        chk("defer hold end", 32'(cur_src), 32'h0);
        chk("defer bd", 32'(burst_done), 32'h1);
        chk("defer last", 32'(out_data), 32'hB3);
        tick();
        chk("defer switch", 32'(cur_src), 32'h1);
        tick();
        chk("defer c0", 32'(out_data), 32'hC0);
        tick();
        chk("defer c1", 32'(out_data), 32'hC1);
        sel = 3'd5;
        q0.delete();
        tick();
        tick();

        // Reset mid-transfer with a buffered word
        sel = 3'd1;
        out_rd_en = 1'b0;
        q1.push_back(8'hD0);
        q1.push_back(8'hD1);
        q1.push_back(8'hD2);
        tick();
        tick();
        tick();
        chk("pre-rst valid", 32'(out_empty), 32'h0);
        chk("pre-rst data", 32'(out_data), 32'hD0);
        chk("pre-rst cur", 32'(cur_src), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_empty", 32'(out_empty), 32'h1);
        chk("async cur_src", 32'(cur_src), 32'h0);
        chk("async out_data", 32'(out_data), 32'h0);
        chk("async rd_en", 32'(src_rd_en), 32'h0);
        @(negedge clk);
        q0.delete();
        q1.delete();
        for (int k = 0; k < 6; k++) begin
            q0.push_back(8'h40 + 8'(k));
            q1.push_back(8'h50 + 8'(k));
        end
        auto_rr = 1'b1;
        out_rd_en = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post-rst rd_en", 32'(src_rd_en), 32'h0);
        chk("post-rst empty", 32'(out_empty), 32'h1);

        // Round-robin bursts of 4
        nbd = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) chk("rr first grant", 32'(cur_src), 32'h0);
            if (!out_empty) log_q.push_back(out_data);
            if (burst_done) nbd++;
        end
        chk("rr word count", 32'(log_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("rr order",
                (i < log_q.size()) ? 32'(log_q[i]) : 32'hDEAD,
                32'(exp_ord[i]));
        end
        chk("rr burst_done", 32'(nbd), 32'd2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
